// File: rtl/usb_data_buffer.sv
// usb_data_buffer
//   Shared endpoint byte FIFO between the AHB-lite register stage and the USB
//   RX/TX packet engines. Either side may push or pop. The head byte is shown
//   ahead on both read ports, so a consumer samples it in the same cycle it
//   strobes its pop.
//
// Ports
//   clk, n_rst            : clock (rising edge), async active-low reset
//   clear                 : synchronous flush, overrides push/pop
//   store_tx_data/tx_data : AHB-side push strobe / byte
//   get_rx_data/rx_data   : AHB-side pop strobe / head byte
//   store_rx_packet_data/rx_packet_data : USB RX push strobe / byte
//   get_tx_packet_data/tx_packet_data   : USB TX pop strobe / head byte
//   buffer_occupancy      : registered entry count, 0..DEPTH
//   overflow, underflow   : registered one-cycle error pulses
module usb_data_buffer #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clear,
    input  logic       store_tx_data,
    input  logic [7:0] tx_data,
    input  logic       get_rx_data,
    output logic [7:0] rx_data,
    input  logic       store_rx_packet_data,
    input  logic [7:0] rx_packet_data,
    input  logic       get_tx_packet_data,
    output logic [7:0] tx_packet_data,
    output logic [6:0] buffer_occupancy,
    output logic       overflow,
    output logic       underflow
);

    // Pointers carry one extra bit so full and empty are distinguishable.
    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] ONE      = PW'(1);
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [PW-1:0] fill, fill_nxt;
    logic [PW-1:0] wptr_nxt, rptr_nxt;
    logic          empty, full;
    logic          push, pop, dual_push;
    logic          do_push, do_pop;
    logic          ovf_nxt, unf_nxt;
    logic [7:0]    wbyte, head;

    always_comb begin
        fill      = wptr - rptr;
        empty     = (fill == '0);
        full      = (fill == FULL_CNT);
        push      = store_rx_packet_data | store_tx_data;
        pop       = get_rx_data | get_tx_packet_data;
        dual_push = store_rx_packet_data & store_tx_data;
        // USB RX byte wins a collision; the AHB byte is lost.
        wbyte     = store_rx_packet_data ? rx_packet_data : tx_data;

        // A pop on empty is ignored even if a push lands the same cycle.
        do_pop    = pop & ~empty;
        // When full, a simultaneous pop frees the slot the push needs.
        do_push   = push & (~full | pop);

        ovf_nxt   = dual_push | (push & full & ~pop);
        unf_nxt   = pop & empty;

        wptr_nxt  = do_push ? wptr + ONE : wptr;
        rptr_nxt  = do_pop  ? rptr + ONE : rptr;
        fill_nxt  = wptr_nxt - rptr_nxt;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr             <= '0;
            rptr             <= '0;
            buffer_occupancy <= '0;
            overflow         <= 1'b0;
            underflow        <= 1'b0;
        end else if (clear) begin
            wptr             <= '0;
            rptr             <= '0;
            buffer_occupancy <= '0;
            overflow         <= 1'b0;
            underflow        <= 1'b0;
        end else begin
            wptr             <= wptr_nxt;
            rptr             <= rptr_nxt;
            buffer_occupancy <= 7'(fill_nxt);
            overflow         <= ovf_nxt;
            underflow        <= unf_nxt;
        end
    end

    // Storage is not reset; the pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (!clear && do_push)
            mem[wptr[ADDR_W-1:0]] <= wbyte;
    end

    always_comb begin
        head           = empty ? 8'd0 : mem[rptr[ADDR_W-1:0]];
        rx_data        = head;
        tx_packet_data = head;
    end

endmodule
